instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000: PC value after reset.
REQ-002 SHALL have port CLK  in  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port IC_Addr_OUT  out  32: word-aligned fetch address presented to the I-cache.
REQ-005 SHALL have port IC_Req_OUT  out  1: fetch request valid to the I-cache.
REQ-006 SHALL have port IC_Instr_IN  in  32: instruction returned by the I-cache for IC_Addr_OUT.
REQ-007 SHALL have port stall_IC  in  1: I-cache miss; IC_Instr_IN is invalid this cycle.
REQ-008 SHALL have port Alt_PC  in  32: branch/jump target from decode.
REQ-009 SHALL have port Request_Alt_PC  in  1: decode requests a redirect to Alt_PC.
REQ-010 SHALL have port WANT_FREEZE  in  1: decode requests that fetch hold its current output.
REQ-011 SHALL have port Instr1_OUT  out  32: instruction passed to decode.
REQ-012 SHALL have port Instr_PC_OUT  out  32: PC of Instr1_OUT.
REQ-013 SHALL have port Instr_PC_Plus4_OUT  out  32: Instr_PC_OUT+4.

Function
REQ-014 SHALL hold internal PC register; IC_Addr_OUT = {PC[31:2],2'b00} combinationally; IC_Req_OUT = 1 in RUN and HOLD states, 0 in BOOT.
REQ-015 SHALL implement states BOOT, RUN, HOLD; BOOT -> RUN on the first clock after reset release; RUN -> HOLD when stall_IC or WANT_FREEZE is 1; HOLD -> RUN when both are 0.
REQ-016 In BOOT, SHALL drive Instr1_OUT = 0 (nop) and leave PC = RESET_VECTOR unchanged.
REQ-017 "Advance" SHALL be defined as state != BOOT && stall_IC == 0 && WANT_FREEZE == 0.
REQ-018 On advance, SHALL register Instr1_OUT <= IC_Instr_IN, Instr_PC_OUT <= PC, Instr_PC_Plus4_OUT <= PC+4 (one-cycle latency from address to decode).
REQ-019 On advance, next PC SHALL be: Alt_PC if Request_Alt_PC; else pending target if pending_valid; else PC+4.
REQ-020 Without advance, SHALL hold PC, Instr1_OUT, Instr_PC_OUT and Instr_PC_Plus4_OUT unchanged (decode re-sees the same instruction during a freeze).
REQ-021 A Request_Alt_PC arriving without advance SHALL be captured into pending_valid/pending_pc; it SHALL NOT be lost.
REQ-022 Simultaneous Request_Alt_PC with pending_valid SHALL overwrite the pending target (newest redirect wins); pending_valid SHALL clear on the advance that consumes it.
REQ-023 Alt_PC[1:0] SHALL be ignored (forced to 00) when loaded into PC or the pending register.
REQ-024 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-025 stall_IC and WANT_FREEZE both 1 SHALL behave as a stall (no advance); release order SHALL be irrelevant.
REQ-026 No instruction fetched before a redirect is squashed: the instruction after a branch (delay slot) SHALL be delivered normally.

Reset
REQ-027 On RESET low, SHALL asynchronously set PC = RESET_VECTOR, state = BOOT, pending_valid = 0, pending_pc = 0, Instr1_OUT = 0, Instr_PC_OUT = 0, Instr_PC_Plus4_OUT = 0, counters = 0.
REQ-028 Reset asserted mid-stall or mid-freeze SHALL discard any pending redirect; fetch restarts at RESET_VECTOR.

Configuration
REQ-029 Macro IF_STATS_EN defined: SHALL add outputs FetchCount_OUT (32) counting advances and StallCount_OUT (32) counting cycles with stall_IC=1 in RUN/HOLD, both saturating at 32'hFFFFFFFF.
REQ-030 Macro IF_STATS_EN undefined: SHALL omit both ports and counters; all other behaviour identical.

Verification
REQ-031 Reset release, stall_IC=0, no redirect -> IC_Addr_OUT BFC00000, BFC00004, BFC00008; Instr_PC_OUT trails by one cycle; Instr1_OUT=0 in BOOT cycle.
REQ-032 Request_Alt_PC=1, Alt_PC=00400103 on an advancing cycle -> next IC_Addr_OUT 00400100; delay-slot instruction delivered first.
REQ-033 stall_IC=1 for 3 cycles with Request_Alt_PC pulsed (Alt_PC=00400200) in cycle 2 -> outputs hold 3 cycles, then fetch from 00400200.
REQ-034 WANT_FREEZE=1 for 4 cycles -> Instr1_OUT/Instr_PC_OUT constant; PC advances once after release.
REQ-035 PC forced to FFFFFFFC via redirect -> Instr_PC_Plus4_OUT=00000000 and next IC_Addr_OUT=00000000.
REQ-036 IF_STATS_EN, 10 advances + 5 stall cycles -> FetchCount_OUT=10, StallCount_OUT=5; RESET low mid-stall -> both 0, IC_Addr_OUT=BFC00000.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- instruction fetch stage
//
// The stage keeps the program counter, presents a word-aligned fetch address
// to the I-cache and registers the returned instruction (plus its PC and
// PC+4) towards decode, with one cycle of latency.
//
// Handshake: an "advance" happens on a rising edge when the FSM is not in BOOT
// and neither stall_IC (I-cache miss) nor WANT_FREEZE (decode hold) is high.
// On an advance the instruction at IC_Addr_OUT is captured and the PC moves on.
// Without an advance every output register holds its value, so decode keeps
// seeing the same instruction. A redirect that arrives on a non-advancing
// cycle is parked in a pending register and is applied on the next advance.
// A redirect on an advancing cycle always wins over a parked one.
//
// Ports:
//   CLK, RESET           clock, asynchronous active-low reset
//   IC_Addr_OUT/Req_OUT  fetch address / request to the I-cache
//   IC_Instr_IN          instruction returned for IC_Addr_OUT
//   stall_IC             I-cache miss (IC_Instr_IN not valid)
//   Alt_PC/Request_Alt_PC  redirect target and request from decode
//   WANT_FREEZE          decode asks fetch to hold its outputs
//   Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT  registered outputs to decode
//   FetchCount_OUT, StallCount_OUT  saturating statistics (only when the
//                        IF_STATS_EN macro is defined)
//   state_dbg_OUT        current FSM state (0 BOOT, 1 RUN, 2 HOLD)
//
// Configuration macro: IF_STATS_EN
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] IC_Addr_OUT,
    output logic        IC_Req_OUT,
    input  logic [31:0] IC_Instr_IN,
    input  logic        stall_IC,
    input  logic [31:0] Alt_PC,
    input  logic        Request_Alt_PC,
    input  logic        WANT_FREEZE,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
`ifdef IF_STATS_EN
    output logic [31:0] FetchCount_OUT,
    output logic [31:0] StallCount_OUT,
`endif
    output logic [1:0]  state_dbg_OUT
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pending_valid_q, pending_valid_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] instr_pc4_q, instr_pc4_d;

    logic        advance;
    logic        hold_req;
    logic [31:0] pc_plus4;
    logic [31:0] alt_aligned;

    assign hold_req    = stall_IC | WANT_FREEZE;
    assign pc_plus4    = pc_q + 32'd4;             // wraps modulo 2^32
    assign alt_aligned = Alt_PC & 32'hFFFF_FFFC;   // low two bits ignored

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = hold_req ? ST_HOLD : ST_RUN;
            ST_HOLD: state_d = hold_req ? ST_HOLD : ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        IC_Req_OUT    = 1'b0;
        advance       = 1'b0;
        state_dbg_OUT = state_q;
        if (state_q == ST_RUN || state_q == ST_HOLD) begin
            IC_Req_OUT = 1'b1;
            advance    = !hold_req;
        end
    end

    assign IC_Addr_OUT = {pc_q[31:2], 2'b00};

    // ---------------------------------------------------------------------
    // Datapath next values
    // ---------------------------------------------------------------------
    always_comb begin
        pc_d            = pc_q;
        pending_valid_d = pending_valid_q;
        pending_pc_d    = pending_pc_q;
        instr_d         = instr_q;
        instr_pc_d      = instr_pc_q;
        instr_pc4_d     = instr_pc4_q;

        if (advance) begin
            instr_d     = IC_Instr_IN;
            instr_pc_d  = pc_q;
            instr_pc4_d = pc_plus4;
            if (Request_Alt_PC) begin
                pc_d = alt_aligned;
            end else if (pending_valid_q) begin
                pc_d = pending_pc_q;
            end else begin
                pc_d = pc_plus4;
            end
            // Either consumed here or superseded by the newer redirect.
            pending_valid_d = 1'b0;
        end else if (Request_Alt_PC) begin
            // Park the redirect; a later one overwrites an earlier one.
            pending_valid_d = 1'b1;
            pending_pc_d    = alt_aligned;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q            <= RESET_VECTOR;
            pending_valid_q <= 1'b0;
            pending_pc_q    <= 32'd0;
            instr_q         <= 32'd0;
            instr_pc_q      <= 32'd0;
            instr_pc4_q     <= 32'd0;
        end else begin
            pc_q            <= pc_d;
            pending_valid_q <= pending_valid_d;
            pending_pc_q    <= pending_pc_d;
            instr_q         <= instr_d;
            instr_pc_q      <= instr_pc_d;
            instr_pc4_q     <= instr_pc4_d;
        end
    end

    assign Instr1_OUT         = instr_q;
    assign Instr_PC_OUT       = instr_pc_q;
    assign Instr_PC_Plus4_OUT = instr_pc4_q;

`ifdef IF_STATS_EN
    // ---------------------------------------------------------------------
    // Statistics: advances, and stall_IC cycles outside BOOT; both saturate.
    // ---------------------------------------------------------------------
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (advance && fetch_cnt_q != 32'hFFFF_FFFF) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (state_q != ST_BOOT && stall_IC && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FetchCount_OUT = fetch_cnt_q;
    assign StallCount_OUT = stall_cnt_q;
`endif

endmodule
